uart_rx: RTL and testbench

Receive-side UART block. It converts the serial line back into parallel bytes and pairs with the existing UART transmitter in the same frame format: start bit 0, DATA_WIDTH data bits LSB first, optional parity, stop bit 1. It runs on the oversampling clock, takes a majority vote of three samples per bit, checks parity and stop bit, and presents each received word with a one-cycle valid pulse to the system-side synchronizer.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_rx_sampler.sv | 43 ++++
 rtl/uart_rx.sv | 177 +++++++++++++++++
 tb/tb_uart_rx.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART frame definitions: receiver FSM encoding, parity types and line levels.
// The TX side uses the same line-level and parity constants.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Parity bit the far end should have sent, given the XOR of the payload.
  function automatic logic par_bit(input logic xor_v, input logic typ);
    case (typ)
      PAR_EVEN: par_bit = xor_v;
      PAR_ODD:  par_bit = ~xor_v;
      default:  par_bit = xor_v;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Three-point sampler around mid-bit with majority vote; bit_o is settled by edge_cnt = P-1.
// No flow control: it follows the edge counter driven by the receiver FSM.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int PRESC_W = 6
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               RX_IN,
  input  logic [PRESC_W-1:0] edge_cnt_i,
  input  logic [PRESC_W-1:0] presc_i,
  output logic               bit_o
);

  logic [2:0]         samp_q;
  logic [2:0]         samp_d;
  logic [PRESC_W-1:0] mid;
  logic               at_sample;

  assign mid       = presc_i >> 1;
  assign at_sample = (edge_cnt_i == mid - PRESC_W'(1)) ||
                     (edge_cnt_i == mid) ||
                     (edge_cnt_i == mid + PRESC_W'(1));

  always_comb begin
    samp_d = samp_q;
    if (at_sample) begin
      samp_d = {samp_q[1:0], RX_IN};
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      samp_q <= {3{STOP_BIT}};
    end else begin
      samp_q <= samp_d;
    end
  end

  assign bit_o = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start/data/parity/stop deframing on the oversampling clock.
// DATA_VALID rises (1 + DATA_WIDTH + PAR_EN)*P + P cycles after the start edge; no backpressure.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESC_W-1:0]    PRESCALE,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VALID,
  output logic                  PAR_ERR,
  output logic                  STP_ERR
);

  localparam int              BCW      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BCW-1:0]  LAST_BIT = BCW'(DATA_WIDTH - 1);

  rx_state_e             state_q,      state_d;
  logic [PRESC_W-1:0]    edge_cnt_q,   edge_cnt_d;
  logic [BCW-1:0]        bit_cnt_q,    bit_cnt_d;
  logic [PRESC_W-1:0]    presc_q,      presc_d;
  logic                  par_en_q,     par_en_d;
  logic                  par_typ_q,    par_typ_d;
  logic [DATA_WIDTH-1:0] shift_q,      shift_d;
  logic                  frame_perr_q, frame_perr_d;
  logic [DATA_WIDTH-1:0] p_data_q,     p_data_d;
  logic                  dv_q,         dv_d;
  logic                  perr_q,       perr_d;
  logic                  serr_q,       serr_d;

  logic samp_bit;
  logic decision;

  uart_rx_sampler #(
    .PRESC_W (PRESC_W)
  ) u_sampler (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .edge_cnt_i (edge_cnt_q),
    .presc_i    (presc_q),
    .bit_o      (samp_bit)
  );

  assign decision = (edge_cnt_q == presc_q - PRESC_W'(1));

  always_comb begin
    state_d      = state_q;
    edge_cnt_d   = edge_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    presc_d      = presc_q;
    par_en_d     = par_en_q;
    par_typ_d    = par_typ_q;
    shift_d      = shift_q;
    frame_perr_d = frame_perr_q;
    p_data_d     = p_data_q;
    dv_d         = 1'b0;
    perr_d       = 1'b0;
    serr_d       = 1'b0;

    if (state_q != IDLE) begin
      edge_cnt_d = decision ? '0 : edge_cnt_q + PRESC_W'(1);
    end

    case (state_q)
      IDLE: begin
        edge_cnt_d = '0;
        bit_cnt_d  = '0;
        // The cycle the falling edge is seen is edge 0 of the start bit.
        if (RX_IN == START_BIT) begin
          state_d      = START;
          edge_cnt_d   = PRESC_W'(1);
          presc_d      = PRESCALE;
          par_en_d     = PAR_EN;
          par_typ_d    = PAR_TYP;
          frame_perr_d = 1'b0;
        end
      end
      START: begin
        if (decision) begin
          state_d   = (samp_bit == START_BIT) ? DATA : IDLE;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (decision) begin
          shift_d[bit_cnt_q] = samp_bit;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
          end
        end
      end
      PARITY: begin
        if (decision) begin
          if (samp_bit != par_bit(^shift_q, par_typ_q)) begin
            perr_d       = 1'b1;
            frame_perr_d = 1'b1;
          end
          state_d = STOP;
        end
      end
      STOP: begin
        if (decision) begin
          if (samp_bit == STOP_BIT) begin
            if (!frame_perr_q) begin
              p_data_d = shift_q;
              dv_d     = 1'b1;
            end
          end else begin
            serr_d = 1'b1;
          end
          // A line already low here is the next start bit; skip IDLE.
          if (RX_IN == START_BIT) begin
            state_d      = START;
            edge_cnt_d   = PRESC_W'(1);
            presc_d      = PRESCALE;
            par_en_d     = PAR_EN;
            par_typ_d    = PAR_TYP;
            frame_perr_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d    = IDLE;
        edge_cnt_d = '0;
        bit_cnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q      <= IDLE;
      edge_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      presc_q      <= '0;
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      shift_q      <= '0;
      frame_perr_q <= 1'b0;
      p_data_q     <= '0;
      dv_q         <= 1'b0;
      perr_q       <= 1'b0;
      serr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      edge_cnt_q   <= edge_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      presc_q      <= presc_d;
      par_en_q     <= par_en_d;
      par_typ_q    <= par_typ_d;
      shift_q      <= shift_d;
      frame_perr_q <= frame_perr_d;
      p_data_q     <= p_data_d;
      dv_q         <= dv_d;
      perr_q       <= perr_d;
      serr_q       <= serr_d;
    end
  end

  assign P_DATA     = p_data_q;
  assign DATA_VALID = dv_q;
  assign PAR_ERR    = perr_q;
  assign STP_ERR    = serr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboarded bench for uart_rx: each driven frame queues its expected flag event,
// and a negedge monitor pops and compares kind, cycle and P_DATA.
module tb_uart_rx;

  localparam int DW = 8;
  localparam int PW = 6;

  logic          CLK      = 1'b0;
  logic          RST      = 1'b0;
  logic          RX_IN    = 1'b1;
  logic [PW-1:0] PRESCALE = 6'd8;
  logic          PAR_EN   = 1'b0;
  logic          PAR_TYP  = 1'b0;
  logic [DW-1:0] P_DATA;
  logic          DATA_VALID;
  logic          PAR_ERR;
  logic          STP_ERR;

  uart_rx #(
    .DATA_WIDTH (DW),
    .PRESC_W    (PW)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .PRESCALE   (PRESCALE),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_ERR    (PAR_ERR),
    .STP_ERR    (STP_ERR)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // kind is {DATA_VALID, PAR_ERR, STP_ERR}
  typedef struct {
    logic [2:0]    kind;
    logic [DW-1:0] data;
    int            cyc;
  } ev_t;

  ev_t           sb[$];
  logic [DW-1:0] exp_pdata = '0;
  int            n_vec = 0;
  int            n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  logic [2:0] mon_obs;
  ev_t        mon_ev;
  always @(negedge CLK) begin
    if (RST) begin
      mon_obs = {DATA_VALID, PAR_ERR, STP_ERR};
      if (mon_obs != 3'b000) begin
        if (sb.size() == 0) begin
          chk("spurious_flag", {29'd0, mon_obs}, 32'd0);
        end else begin
          mon_ev = sb.pop_front();
          chk("flag_kind", {29'd0, mon_obs}, {29'd0, mon_ev.kind});
          chk("flag_cycle", cyc, mon_ev.cyc);
          chk("p_data", {24'd0, P_DATA}, {24'd0, mon_ev.data});
        end
      end
    end
  end

  // All driving happens 1 time unit after a posedge; tasks leave that alignment intact.
  task automatic drive_bit(input logic b, input int p, input int flip_at);
    for (int j = 0; j < p; j++) begin
      RX_IN = (j == flip_at) ? ~b : b;
      @(posedge CLK); #1;
    end
  endtask

  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input int p, input logic pen,
                            input logic ptyp, input logic pbit, input logic sbit,
                            input int flip_bit);
    ev_t  e;
    int   c;
    int   pen_i;
    logic par_ok;
    PRESCALE = p[PW-1:0];
    PAR_EN   = pen;
    PAR_TYP  = ptyp;
    c        = cyc;
    pen_i    = pen ? 1 : 0;
    par_ok   = !pen || (pbit == ((^d) ^ ptyp));
    if (!par_ok) begin
      e.kind = 3'b010; e.data = exp_pdata; e.cyc = c + (2 + DW) * p;
      sb.push_back(e);
    end
    if (!sbit) begin
      e.kind = 3'b001; e.data = exp_pdata; e.cyc = c + (2 + DW + pen_i) * p;
      sb.push_back(e);
    end
    if (par_ok && sbit) begin
      exp_pdata = d;
      e.kind = 3'b100; e.data = d; e.cyc = c + (2 + DW + pen_i) * p;
      sb.push_back(e);
    end
    drive_bit(1'b0, p, -1);
    for (int i = 0; i < DW; i++) drive_bit(d[i], p, (i == flip_bit) ? p / 2 : -1);
    if (pen) drive_bit(pbit, p, -1);
    drive_bit(sbit, p, -1);
    RX_IN = 1'b1;
  endtask

  task automatic wait_drain(input int max_cyc);
    int n = 0;
    while (sb.size() != 0 && n < max_cyc) begin
      @(posedge CLK);
      n++;
    end
    #1;
    chk("drain_timeout", sb.size(), 32'd0);
  endtask

  initial begin
    RST = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_p_data", {24'd0, P_DATA}, 32'd0);
    chk("rst_data_valid", {31'd0, DATA_VALID}, 32'd0);
    chk("rst_par_err", {31'd0, PAR_ERR}, 32'd0);
    chk("rst_stp_err", {31'd0, STP_ERR}, 32'd0);
    @(posedge CLK); #1;
    RST = 1'b1;
    idle(4);

    // 8N1 at P=8, back-to-back frames
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    wait_drain(200);
    chk("b2b_p_data", {24'd0, P_DATA}, 32'h3C);
    idle(8);

    // 8E1 at P=16: good parity, then bad parity
    send_frame(8'h07, 16, 1'b1, 1'b0, 1'b1, 1'b1, -1);
    wait_drain(200);
    send_frame(8'h07, 16, 1'b1, 1'b0, 1'b0, 1'b1, -1);
    wait_drain(200);
    chk("perr_p_data_held", {24'd0, P_DATA}, 32'h07);
    idle(8);

    // 8O1 at P=32 with the stop bit forced low
    send_frame(8'h00, 32, 1'b1, 1'b1, 1'b1, 1'b0, -1);
    wait_drain(400);
    idle(2 * 32 + 4);
    chk("serr_p_data_held", {24'd0, P_DATA}, 32'h07);

    // Two-cycle start glitch at P=16
    PRESCALE = 6'd16;
    PAR_EN   = 1'b0;
    RX_IN    = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    idle(48);
    chk("glitch_p_data", {24'd0, P_DATA}, 32'h07);

    // Single-cycle flip on the centre sample of data bit 3
    send_frame(8'hC9, 16, 1'b0, 1'b0, 1'b0, 1'b1, 3);
    wait_drain(300);
    chk("noise_p_data", {24'd0, P_DATA}, 32'hC9);
    idle(8);

    // Reset part-way through data bit 4
    PRESCALE = 6'd8;
    PAR_EN   = 1'b0;
    drive_bit(1'b0, 8, -1);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, 8, -1);
    drive_bit(1'b1, 4, -1);
    RST = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    chk("midrst_p_data", {24'd0, P_DATA}, 32'd0);
    chk("midrst_data_valid", {31'd0, DATA_VALID}, 32'd0);
    chk("midrst_flags", {30'd0, PAR_ERR, STP_ERR}, 32'd0);
    @(posedge CLK); #1;
    RST       = 1'b1;
    exp_pdata = '0;
    idle(4);
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    wait_drain(200);
    chk("post_rst_p_data", {24'd0, P_DATA}, 32'h5A);
    idle(8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
